// File: rtl/fully_connected_fprop_pkg.sv
// rtl/fully_connected_fprop_pkg.sv - shared widths and state encoding for the fprop index generator
package fully_connected_fprop_pkg;

  localparam int ROW_WIDTH = 11;
  localparam int LEN_WIDTH = 6;
  localparam int CNT_WIDTH = ROW_WIDTH + LEN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fully_connected_fprop_wrap_cnt.sv
// rtl/fully_connected_fprop_wrap_cnt.sv - counter that wraps to zero after reaching a runtime limit
module fully_connected_fprop_wrap_cnt #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // wrap fires on the enabled step that leaves the limit value
  assign wrap  = en && (count_q == limit);
  assign count = count_q;

  // next count: clear wins, then wrap to zero or advance
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fully_connected_fprop_idx_gen.sv
// rtl/fully_connected_fprop_idx_gen.sv - row-major (row, col) beat generator for a fully connected forward pass
module fully_connected_fprop_idx_gen #(
  parameter int ROW_WIDTH = fully_connected_fprop_pkg::ROW_WIDTH,
  parameter int LEN_WIDTH = fully_connected_fprop_pkg::LEN_WIDTH,
  parameter int CNT_WIDTH = fully_connected_fprop_pkg::CNT_WIDTH
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [ROW_WIDTH-1:0] num_out,
  input  logic [LEN_WIDTH-1:0] num_in,
  output logic [ROW_WIDTH-1:0] op_row,
  output logic [LEN_WIDTH-1:0] op_len,
  output logic [LEN_WIDTH-1:0] op_col,
  output logic                 op_last_col,
  output logic                 op_last_row,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  typedef fully_connected_fprop_pkg::state_t state_t;

  state_t               state_q, state_d;
  logic [ROW_WIDTH-1:0] rows_q, rows_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 op_valid_q, op_valid_d;
  logic                 last_col_q, last_col_d;
  logic                 last_row_q, last_row_d;
  logic                 ap_done_q, ap_done_d;
  logic                 ap_ready_q, ap_ready_d;
  logic                 ap_idle_q, ap_idle_d;

  logic                 fire;
  logic                 start_acc;
  logic                 col_wrap;
  logic                 row_wrap;
  logic [ROW_WIDTH-1:0] rows_lim;
  logic [LEN_WIDTH-1:0] len_lim;
  logic [ROW_WIDTH-1:0] row_nxt;
  logic [LEN_WIDTH-1:0] col_nxt;

  assign fire      = op_valid_q && op_ready;
  assign start_acc = (state_q == fully_connected_fprop_pkg::ST_IDLE) && ap_start;
  assign rows_lim  = rows_q - ROW_WIDTH'(1);
  assign len_lim   = len_q - LEN_WIDTH'(1);

  // column index advances on every accepted beat and wraps at num_in-1
  fully_connected_fprop_wrap_cnt #(.WIDTH(LEN_WIDTH)) u_col_cnt (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .clr   (start_acc),
    .en    (fire),
    .limit (len_lim),
    .count (op_col),
    .wrap  (col_wrap)
  );

  // row index advances once per completed row
  fully_connected_fprop_wrap_cnt #(.WIDTH(ROW_WIDTH)) u_row_cnt (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .clr   (start_acc),
    .en    (col_wrap),
    .limit (rows_lim),
    .count (op_row),
    .wrap  (row_wrap)
  );

  // indices of the beat that follows the current one, used to pre-register the last flags
  assign col_nxt = last_col_q ? '0 : op_col + LEN_WIDTH'(1);
  assign row_nxt = last_col_q ? op_row + ROW_WIDTH'(1) : op_row;

  // state machine next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    op_valid_d = op_valid_q;
    last_col_d = last_col_q;
    last_row_d = last_row_q;
    ap_done_d  = 1'b0;
    ap_ready_d = 1'b0;
    ap_idle_d  = 1'b0;
    unique case (state_q)
      fully_connected_fprop_pkg::ST_IDLE: begin
        ap_idle_d = 1'b1;
        if (ap_start) begin
          rows_d     = num_out;
          len_d      = num_in;
          beat_cnt_d = '0;
          ap_idle_d  = 1'b0;
          if ((num_out == '0) || (num_in == '0)) begin
            state_d    = fully_connected_fprop_pkg::ST_DONE;
            ap_done_d  = 1'b1;
            ap_ready_d = 1'b1;
          end else begin
            state_d    = fully_connected_fprop_pkg::ST_RUN;
            op_valid_d = 1'b1;
            last_col_d = (num_in == LEN_WIDTH'(1));
            last_row_d = (num_out == ROW_WIDTH'(1)) && (num_in == LEN_WIDTH'(1));
          end
        end
      end
      fully_connected_fprop_pkg::ST_RUN: begin
        if (fire) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          if (row_wrap) begin
            state_d    = fully_connected_fprop_pkg::ST_DONE;
            op_valid_d = 1'b0;
            last_col_d = 1'b0;
            last_row_d = 1'b0;
            ap_done_d  = 1'b1;
            ap_ready_d = 1'b1;
          end else begin
            last_col_d = (col_nxt == len_lim);
            last_row_d = (col_nxt == len_lim) && (row_nxt == rows_lim);
          end
        end
      end
      fully_connected_fprop_pkg::ST_DONE: begin
        state_d   = fully_connected_fprop_pkg::ST_IDLE;
        ap_idle_d = 1'b1;
      end
      default: begin
        state_d    = fully_connected_fprop_pkg::ST_IDLE;
        op_valid_d = 1'b0;
        ap_idle_d  = 1'b1;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= fully_connected_fprop_pkg::ST_IDLE;
      rows_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      op_valid_q <= 1'b0;
      last_col_q <= 1'b0;
      last_row_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_ready_q <= 1'b0;
      ap_idle_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      op_valid_q <= op_valid_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
      ap_done_q  <= ap_done_d;
      ap_ready_q <= ap_ready_d;
      ap_idle_q  <= ap_idle_d;
    end
  end

  assign ap_done     = ap_done_q;
  assign ap_ready    = ap_ready_q;
  assign ap_idle     = ap_idle_q;
  assign op_len      = len_q;
  assign op_valid    = op_valid_q;
  assign op_last_col = last_col_q;
  assign op_last_row = last_row_q;
  assign beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_fully_connected_fprop_idx_gen.sv
// tb/tb_fully_connected_fprop_idx_gen.sv - directed self-checking bench for the fprop index generator
module tb_fully_connected_fprop_idx_gen;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [10:0] num_out;
  logic [5:0]  num_in;
  logic [10:0] op_row;
  logic [5:0]  op_len;
  logic [5:0]  op_col;
  logic        op_last_col;
  logic        op_last_row;
  logic        op_valid;
  logic        op_ready;
  logic [16:0] beat_cnt;

  int checks;
  int failures;

  fully_connected_fprop_idx_gen dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .num_out     (num_out),
    .num_in      (num_in),
    .op_row      (op_row),
    .op_len      (op_len),
    .op_col      (op_col),
    .op_last_col (op_last_col),
    .op_last_row (op_last_row),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .beat_cnt    (beat_cnt)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    int  exp_idx;
    int  cyc;
    bit  done_seen;
    bit  rdy;
    logic [10:0] hold_row;
    logic [5:0]  hold_col;

    checks   = 0;
    failures = 0;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    num_out  = '0;
    num_in   = '0;
    op_ready = 1'b0;
    step();
    step();

    // reset state
    check("rst_idle",  32'(ap_idle), 1);
    check("rst_valid", 32'(op_valid), 0);
    check("rst_done",  32'(ap_done), 0);
    check("rst_ready", 32'(ap_ready), 0);
    check("rst_cnt",   32'(beat_cnt), 0);
    check("rst_len",   32'(op_len), 0);
    ap_rst = 1'b0;
    step();

    // 3 x 4 at full throughput; num_out changed mid-run must not matter
    num_out  = 11'd3;
    num_in   = 6'd4;
    op_ready = 1'b1;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    num_out  = 11'd7;
    num_in   = 6'd9;
    for (int i = 0; i < 12; i++) begin
      check("a_valid",    32'(op_valid), 1);
      check("a_idle",     32'(ap_idle), 0);
      check("a_row",      32'(op_row), 32'(i / 4));
      check("a_col",      32'(op_col), 32'(i % 4));
      check("a_last_col", 32'(op_last_col), 32'((i % 4) == 3));
      check("a_last_row", 32'(op_last_row), 32'(i == 11));
      check("a_len",      32'(op_len), 4);
      check("a_cnt",      32'(beat_cnt), 32'(i));
      step();
    end
    check("a_done",     32'(ap_done), 1);
    check("a_ap_ready", 32'(ap_ready), 1);
    check("a_done_vld", 32'(op_valid), 0);
    check("a_done_idl", 32'(ap_idle), 0);
    check("a_cnt_end",  32'(beat_cnt), 12);
    step();
    check("a_back_idle", 32'(ap_idle), 1);
    check("a_back_done", 32'(ap_done), 0);

    // 2 x 2 with random backpressure
    num_out  = 11'd2;
    num_in   = 6'd2;
    ap_start = 1'b1;
    step();
    ap_start  = 1'b0;
    exp_idx   = 0;
    done_seen = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (ap_done) begin
        done_seen = 1'b1;
        break;
      end
      check("b_valid",    32'(op_valid), 1);
      check("b_row",      32'(op_row), 32'(exp_idx / 2));
      check("b_col",      32'(op_col), 32'(exp_idx % 2));
      check("b_last_col", 32'(op_last_col), 32'((exp_idx % 2) == 1));
      check("b_last_row", 32'(op_last_row), 32'(exp_idx == 3));
      check("b_cnt",      32'(beat_cnt), 32'(exp_idx));
      rdy      = 1'($urandom_range(0, 1));
      op_ready = rdy;
      step();
      if (rdy) exp_idx++;
    end
    check("b_done_seen", 32'(done_seen), 1);
    check("b_beats",     32'(exp_idx), 4);
    check("b_cnt_end",   32'(beat_cnt), 4);
    op_ready = 1'b1;
    step();

    // zero-row job goes straight to done
    num_out  = 11'd0;
    num_in   = 6'd5;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check("c_done",  32'(ap_done), 1);
    check("c_valid", 32'(op_valid), 0);
    check("c_cnt",   32'(beat_cnt), 0);
    step();
    check("c_idle",  32'(ap_idle), 1);
    check("c_valid2", 32'(op_valid), 0);

    // single-column rows
    num_out  = 11'd5;
    num_in   = 6'd1;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("d_valid",    32'(op_valid), 1);
      check("d_row",      32'(op_row), 32'(i));
      check("d_col",      32'(op_col), 0);
      check("d_last_col", 32'(op_last_col), 1);
      check("d_last_row", 32'(op_last_row), 32'(i == 4));
      step();
    end
    check("d_done", 32'(ap_done), 1);
    check("d_cnt",  32'(beat_cnt), 5);
    step();

    // reset while a beat is stalled, with a start pending
    num_out  = 11'd3;
    num_in   = 6'd3;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    step();
    step();
    op_ready = 1'b0;
    check("e_stall_row", 32'(op_row), 0);
    check("e_stall_col", 32'(op_col), 2);
    check("e_stall_lc",  32'(op_last_col), 1);
    hold_row = op_row;
    hold_col = op_col;
    step();
    step();
    check("e_hold_vld", 32'(op_valid), 1);
    check("e_hold_row", 32'(op_row), 32'(hold_row));
    check("e_hold_col", 32'(op_col), 32'(hold_col));
    check("e_hold_cnt", 32'(beat_cnt), 2);
    ap_rst   = 1'b1;
    ap_start = 1'b1;
    step();
    ap_rst   = 1'b0;
    ap_start = 1'b0;
    check("e_rst_valid", 32'(op_valid), 0);
    check("e_rst_idle",  32'(ap_idle), 1);
    check("e_rst_cnt",   32'(beat_cnt), 0);
    check("e_rst_col",   32'(op_col), 0);
    check("e_rst_len",   32'(op_len), 0);
    step();
    check("e_discard_idle",  32'(ap_idle), 1);
    check("e_discard_valid", 32'(op_valid), 0);
    op_ready = 1'b1;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check("e_fresh_vld", 32'(op_valid), 1);
    check("e_fresh_row", 32'(op_row), 0);
    check("e_fresh_col", 32'(op_col), 0);
    for (int i = 0; i < 9; i++) step();
    check("e_fresh_done", 32'(ap_done), 1);
    check("e_fresh_cnt",  32'(beat_cnt), 9);
    step();

    // maximum job with ap_start held high, followed by an immediate restart
    num_out   = 11'd2047;
    num_in    = 6'd63;
    ap_start  = 1'b1;
    step();
    done_seen = 1'b0;
    for (cyc = 0; cyc < 130000; cyc++) begin
      if (ap_done) begin
        done_seen = 1'b1;
        break;
      end
      if (op_last_row) begin
        check("f_last_row", 32'(op_row), 2046);
        check("f_last_col", 32'(op_col), 62);
      end
      step();
    end
    check("f_done_seen", 32'(done_seen), 1);
    check("f_cnt",       32'(beat_cnt), 128961);
    check("f_valid",     32'(op_valid), 0);
    step();
    check("f_idle", 32'(ap_idle), 1);
    step();
    check("f_restart_vld", 32'(op_valid), 1);
    check("f_restart_row", 32'(op_row), 0);
    check("f_restart_col", 32'(op_col), 0);
    check("f_restart_cnt", 32'(beat_cnt), 0);
    ap_start = 1'b0;
    ap_rst   = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
